// File: rtl/seq_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_pattern_gen_pkg
// Brief   : Shared types, default sizes and helpers for seq_pattern_gen.
// Rev     : 1.0  initial release
// ============================================================================
package seq_pattern_gen_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_REPS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_e;

    // A repeat count of zero still sends the word once.
    function automatic int unsigned eff_reps(input int unsigned reps);
        return (reps == 0) ? 1 : reps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_piso.sv
`default_nettype none
// ============================================================================
// Module  : seq_piso
// Brief   : Parallel-in serial-out shift register, MSB first; load wins.
// Rev     : 1.0  initial release
// ============================================================================
module seq_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign sout = r_data[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : seq_pattern_gen
// Brief   : Serial pattern transmitter with repeat count. Define
//           SEQ_PATTERN_GEN_PARITY_EN to append an even-parity bit per rep.
// Rev     : 1.0  initial release
// ============================================================================
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int REPS_W = DEFAULT_REPS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WIDTH-1:0]  load_data,
    input  logic [REPS_W-1:0] load_reps,
    output logic              dout,
    output logic              dout_valid,
    output logic              sof,
    output logic              busy,
    output logic              done
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_IDX_TOP = CNT_W'(WIDTH - 1);

    state_e            r_state;
    logic [WIDTH-1:0]  r_word;
    logic [REPS_W-1:0] r_reps;
    logic [CNT_W-1:0]  r_idx;
    logic              r_dout_valid;
    logic              r_sof;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_last_rep;
    logic              w_rep_end;
    logic              w_piso_load;
    logic              w_piso_shift;
    logic [WIDTH-1:0]  w_piso_din;

    assign load_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept   = load_valid && load_ready;
    assign w_last_rep = (r_reps <= REPS_W'(1));

    // w_rep_end marks the final cycle of a repetition (parity bit if enabled).
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    assign w_rep_end = (r_state == ST_PAR);
`else
    assign w_rep_end = (r_state == ST_SHIFT) && (r_idx == '0);
`endif

    // The shift register always holds the bit on dout in its MSB, so an idle
    // block keeps it cleared and dout reads 0.
    always_comb begin
        w_piso_load  = 1'b0;
        w_piso_shift = 1'b0;
        w_piso_din   = '0;
        if (w_rep_end) begin
            w_piso_load = 1'b1;
            w_piso_din  = w_last_rep ? '0 : r_word;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_piso_load = 1'b1;
                        w_piso_din  = load_data;
                    end
                end
                ST_SHIFT: begin
                    if (r_idx != '0) begin
                        w_piso_shift = 1'b1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                    end else begin
                        w_piso_load = 1'b1;
                        w_piso_din  = {^r_word, {(WIDTH-1){1'b0}}};
`endif
                    end
                end
                default: begin
                    w_piso_load = 1'b1;
                    w_piso_din  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_reps       <= '0;
            r_idx        <= '0;
            r_dout_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_sof  <= 1'b0;
            if (w_rep_end) begin
                if (!w_last_rep) begin
                    r_state <= ST_SHIFT;
                    r_reps  <= r_reps - REPS_W'(1);
                    r_idx   <= C_IDX_TOP;
                    r_sof   <= 1'b1;
                end else begin
                    r_state      <= ST_IDLE;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_state      <= ST_SHIFT;
                            r_word       <= load_data;
                            r_reps       <= REPS_W'(eff_reps(int'(load_reps)));
                            r_idx        <= C_IDX_TOP;
                            r_dout_valid <= 1'b1;
                            r_sof        <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (r_idx != '0) begin
                            r_idx <= r_idx - CNT_W'(1);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                        end else begin
                            r_state <= ST_PAR;
`endif
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    seq_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_piso_load),
        .shift (w_piso_shift),
        .din   (w_piso_din),
        .sout  (dout)
    );

    assign dout_valid = r_dout_valid;
    assign sof        = r_sof;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_pattern_gen
// Brief   : Directed self-checking bench for seq_pattern_gen (WIDTH=8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_pattern_gen;

    localparam int W = 8;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    localparam int PER = W + 1;
`else
    localparam int PER = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic [3:0] load_reps = '0;
    logic       dout, dout_valid, sof, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    seq_pattern_gen #(
        .WIDTH  (W),
        .REPS_W (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_reps  (load_reps),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sof        (sof),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a load and returns sampling cycle N+1 of the accepting edge N.
    task automatic start_load(input logic [7:0] data, input logic [3:0] reps);
        chk("ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        load_data  = data;
        load_reps  = reps;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        load_reps  = '0;
    endtask

    function automatic logic exp_bit(input logic [7:0] data, input int pos);
        if (pos == W) return ^data;
        return data[W-1-pos];
    endfunction

    // Walks one full frame from cycle N+1 and ends in the done cycle.
    task automatic check_frame(input logic [7:0] data, input int reps);
        for (int k = 0; k < reps * PER; k++) begin
            chk("dout", dout, exp_bit(data, k % PER));
            chk("dout_valid", dout_valid, 1);
            chk("sof", sof, (k % PER) == 0);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("ready_busy", load_ready, 0);
            step();
        end
        chk("done", done, 1);
        chk("done_dout_valid", dout_valid, 0);
        chk("done_dout", dout, 0);
        chk("done_sof", sof, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", load_ready, 1);
    endtask

    initial begin
        // Reset state
        step(); step(); step();
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_sof", sof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", load_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", load_ready, 1);
        step();

        // Basic, repeated and zero-rep frames
        start_load(8'b0111_0001, 4'd1);
        check_frame(8'b0111_0001, 1);
        step();
        chk("done_pulse_width", done, 0);
        start_load(8'hA5, 4'd3);
        check_frame(8'hA5, 3);
        step();
        start_load(8'hFF, 4'd0);
        check_frame(8'hFF, 1);
        step();

`ifndef SEQ_PATTERN_GEN_PARITY_EN
        // Load ignored while busy, then a held load chained off the done cycle
        start_load(8'h3C, 4'd1);
        for (int k = 1; k <= W; k++) begin
            chk("b2b_dout", dout, exp_bit(8'h3C, k - 1));
            chk("b2b_sof", sof, k == 1);
            chk("b2b_dout_valid", dout_valid, 1);
            if (k == 3) begin
                load_valid = 1'b1;
                load_data  = 8'h00;
                load_reps  = 4'd1;
            end else if (k == 4) begin
                load_valid = 1'b0;
            end else if (k == W) begin
                load_valid = 1'b1;
                load_data  = 8'h81;
                load_reps  = 4'd1;
            end
            step();
        end
        chk("b2b_done", done, 1);
        chk("b2b_ready", load_ready, 1);
        chk("b2b_gap_valid", dout_valid, 0);
        step();
        load_valid = 1'b0;
        check_frame(8'h81, 1);
        step();
`else
        start_load(8'b0111_0001, 4'd2);
        check_frame(8'b0111_0001, 2);
        step();
`endif

        // Reset mid-frame
        start_load(8'hA5, 4'd2);
        step(); step(); step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_dout_valid", dout_valid, 0);
        chk("mid_rst_sof", sof, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", load_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_ready_after_rst", load_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_no_done", done, 0);
            chk("mid_idle_valid", dout_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: the sending end of the single-bit serial stream our sequence detectors monitor.
- Accepts a parallel pattern word through a valid/ready load port and shifts it out MSB first, one bit per clock.
- Repeats the word a programmable number of times, back-to-back with no gap.
- Used to drive detector benches and on-chip serial test stimulus.

Parameters:
- WIDTH, 8, pattern length in bits (>=2).
- REPS_W, 4, width of the repeat-count field.
- CNT_W, $clog2(WIDTH), localparam, bit-index counter width (not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  block can accept a load.
- load_data  in  WIDTH  pattern to send; bit WIDTH-1 is sent first.
- load_reps  in  REPS_W  number of pattern repetitions; 0 is treated as 1.
- dout  out  1  serial data bit.
- dout_valid  out  1  dout carries a live bit.
- sof  out  1  high on the first bit of each repetition.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final bit of the frame.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high (port rst, sampled on the rising edge of clk).
- Reset values: dout=0, dout_valid=0, sof=0, busy=0, done=0. State=IDLE, shift register=0, counters=0. load_ready=0 while rst=1.
- load_ready = (state==IDLE) && !rst, combinational.
- Load handshake: a load is accepted at edge N when load_valid && load_ready. load_data and load_reps are captured at that edge.
  - A load_valid while not ready is ignored; nothing is captured.
  - Inputs need not be held after acceptance.
- States:
  - IDLE: wait for a load.
  - SHIFT: send pattern bits.
  - PAR: parity bit; exists only with the optional feature.
- Transitions:
  - IDLE->SHIFT on accept.
  - SHIFT: bit index counts WIDTH-1 down to 0.
  - At index 0 with remaining reps>1: reload the shift register from the captured word, decrement reps, stay in SHIFT.
  - At index 0 on the last rep: go to IDLE.
- Output timing (all outputs registered):
  - First bit appears in cycle N+1 with dout_valid=1 and sof=1.
  - Bits are contiguous: cycle N+k carries bit WIDTH-k of the current repetition.
  - sof is high in cycles N+1, N+1+WIDTH, N+1+2*WIDTH, ...
- Completion, for R reps without parity:
  - The last bit is in cycle N+R*WIDTH.
  - In cycle N+R*WIDTH+1: done=1, dout_valid=0, busy=0, load_ready=1.
- Back-to-back: a load accepted at the edge closing the done cycle starts its first bit the next cycle. The minimum inter-frame gap is exactly one idle cycle.
- busy is high from cycle N+1 through the last bit.
- When dout_valid=0, dout=0 and sof=0.
- Reset mid-frame: the next edge forces all outputs to reset values and state to IDLE. No done pulse is produced, and the partial frame is abandoned.
- Counter widths: the rep counter is REPS_W bits and load_reps=all-ones is legal. The bit index is CNT_W bits and never wraps beyond WIDTH-1.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_PARITY_EN.
- Defined:
  - After bit 0 of every repetition, a PAR cycle emits the even-parity bit (XOR of the WIDTH data bits) with dout_valid=1 and sof=0.
  - Each repetition is WIDTH+1 cycles.
  - sof positions become N+1+k*(WIDTH+1).
  - done comes at N+R*(WIDTH+1)+1.
- Undefined: no PAR state or parity logic; timing as above.

Decomposition:
- Package seq_pattern_gen_pkg holds:
  - state enum (IDLE, SHIFT, PAR);
  - default WIDTH/REPS_W constants;
  - effective-reps function (0->1).
- Sub-module seq_piso: WIDTH-bit parallel-in serial-out shift register with load/shift enables and a serial MSB output. The top keeps the FSM, counters and handshake.

Test Plan:
- Basic frame: load 8'b0111_0001, reps=1, accepted at N -> dout 0,1,1,1,0,0,0,1 in N+1..N+8; sof only at N+1; done at N+9; load_ready=1 at N+9.
- Repeat: 8'hA5, reps=3 -> 24 contiguous bits of 1010_0101 x3; sof at N+1,N+9,N+17; done at N+25.
- Zero reps: 8'hFF, reps=0 -> exactly one 8-bit frame; done at N+9.
- Back-to-back and ignore while busy:
  - Pulse load_valid with 8'h00 at N+3 -> ignored; frame unchanged.
  - Hold load_valid with 8'h81 through the done cycle -> accepted at N+9; new first bit 1 at N+10.
- Reset mid-frame: assert rst at N+4 -> next cycle all outputs 0, no done pulse; load_ready=1 the first cycle after rst drops.
- Parity (macro defined): 8'b0111_0001 (four ones), reps=2 -> 9-bit repetitions, parity bit 0 at N+9 and N+18; sof at N+1,N+10; done at N+19.
